// File: rtl/bkm_bus_master.sv
// BKM slot-bus initiator: runs one address cycle and one data cycle per command and returns read data.
// Optional card interrupt synchroniser and sticky flag, enabled by defining BKM_BUS_MASTER_IRQ_EN.
`timescale 1ns/1ps
module bkm_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       slot_x_int_x,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic [7:0] ad_out,
    output logic       ad_oe_x,
    input  logic [7:0] ad_in,
    input  logic       irq_x,
    input  logic       irq_clear,
    output logic       irq_pending
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_A_SETUP  = 3'd1;
    localparam logic [2:0] S_A_STROBE = 3'd2;
    localparam logic [2:0] S_A_HOLD   = 3'd3;
    localparam logic [2:0] S_D_SETUP  = 3'd4;
    localparam logic [2:0] S_D_STROBE = 3'd5;
    localparam logic [2:0] S_D_HOLD   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_load;
    logic       last;
    logic       wr_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       in_a;
    logic       in_d;

    assign last = (cnt == 8'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (cmd_valid) state_nxt = S_A_SETUP;
            S_A_SETUP:  if (last) state_nxt = S_A_STROBE;
            S_A_STROBE: if (last) state_nxt = S_A_HOLD;
            S_A_HOLD:   if (last) state_nxt = S_D_SETUP;
            S_D_SETUP:  if (last) state_nxt = S_D_STROBE;
            S_D_STROBE: if (last) state_nxt = S_D_HOLD;
            S_D_HOLD:   if (last) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // The down-counter is reloaded with (width - 1) whenever a new state is entered.
    always_comb begin
        cnt_load = 8'd0;
        case (state_nxt)
            S_A_SETUP, S_D_SETUP:   cnt_load = SETUP_LOAD;
            S_A_STROBE, S_D_STROBE: cnt_load = STROBE_LOAD;
            S_A_HOLD, S_D_HOLD:     cnt_load = HOLD_LOAD;
            default:                cnt_load = 8'd0;
        endcase
    end

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= cnt_load;
            end else if (!last) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else if (state == S_IDLE && cmd_valid) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Card data is taken on the edge that ends the data strobe.
    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 8'h00;
        end else if (state == S_D_STROBE && last && !wr_q) begin
            rsp_rdata <= ad_in;
        end
    end

    assign in_a = (state == S_A_SETUP) || (state == S_A_STROBE) || (state == S_A_HOLD);
    assign in_d = (state == S_D_SETUP) || (state == S_D_STROBE) || (state == S_D_HOLD);

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign rsp_valid    = (state == S_DONE);
    assign slot_x_int_x = !(in_a || in_d);
    assign clk_rw       = !((state == S_A_STROBE) || (state == S_D_STROBE));
    assign ax_d         = !in_a;
    assign r_wx         = (in_a || in_d) ? !wr_q : 1'b1;
    assign ad_out       = in_a ? addr_q : ((in_d && wr_q) ? wdata_q : 8'h00);
    assign ad_oe_x      = !(in_a || (in_d && wr_q));

`ifdef BKM_BUS_MASTER_IRQ_EN
    logic irq_s1;
    logic irq_s2;

    // Set has priority over clear while the synchronised line is still low.
    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            irq_s1      <= 1'b1;
            irq_s2      <= 1'b1;
            irq_pending <= 1'b0;
        end else begin
            irq_s1      <= irq_x;
            irq_s2      <= irq_s1;
            irq_pending <= !irq_s2 || (irq_pending && !irq_clear);
        end
    end
`else
    logic unused_irq;
    assign unused_irq  = ^{irq_x, irq_clear};
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_bkm_bus_master.sv
// Bench for bkm_bus_master: cycle-position reference model of the bus, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_bkm_bus_master;

    localparam int S  = 2;
    localparam int ST = 4;
    localparam int H  = 2;
    localparam int T  = S + ST + H;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr  = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       slot_x_int_x;
    logic       clk_rw;
    logic       ax_d;
    logic       r_wx;
    logic [7:0] ad_out;
    logic       ad_oe_x;
    logic [7:0] ad_in;
    logic       irq_x     = 1'b1;
    logic       irq_clear = 1'b0;
    logic       irq_pending;

    logic [7:0] card_data = 8'h00;
    logic [7:0] junk      = 8'hE7;

    // Card: drives its data only while a read data strobe is on the pins.
    assign ad_in = (!slot_x_int_x && !clk_rw && ax_d && r_wx) ? card_data : junk;

    bkm_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H)) dut (
        .clk_50mhz_in(clk),
        .reset(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .slot_x_int_x(slot_x_int_x),
        .clk_rw(clk_rw),
        .ax_d(ax_d),
        .r_wx(r_wx),
        .ad_out(ad_out),
        .ad_oe_x(ad_oe_x),
        .ad_in(ad_in),
        .irq_x(irq_x),
        .irq_clear(irq_clear),
        .irq_pending(irq_pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_n counts edges since acceptance; positions 0..2T-1 are bus cycles, 2T is the response cycle.
    logic       m_act   = 1'b0;
    int         m_n     = 0;
    logic       m_wr    = 1'b0;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_n     <= 0;
            m_rdata <= 8'h00;
            exp_q.delete();
        end else if (!m_act) begin
            if (cmd_valid) begin
                m_act   <= 1'b1;
                m_n     <= 0;
                m_wr    <= cmd_write;
                m_addr  <= cmd_addr;
                m_wdata <= cmd_wdata;
            end
        end else begin
            if (m_n == T + S + ST - 1 && !m_wr) m_rdata <= card_data;
            if (m_n == 2 * T - 1) exp_q.push_back(m_wr ? m_rdata : m_rdata);
            if (m_n == 2 * T) m_act <= 1'b0;
            else m_n <= m_n + 1;
        end
    end

    function automatic logic [24:0] model_vec();
        logic ready, bsy, rv, slot, crw, axd, rwx, oe;
        logic [7:0] ado;
        int m;
        ready = 1'b1; bsy = 1'b0; rv = 1'b0; slot = 1'b1; crw = 1'b1;
        axd = 1'b1; rwx = 1'b1; ado = 8'h00; oe = 1'b1;
        if (m_act) begin
            ready = 1'b0;
            bsy   = 1'b1;
            if (m_n == 2 * T) begin
                rv = 1'b1;
            end else begin
                m    = m_n % T;
                slot = 1'b0;
                axd  = (m_n >= T);
                crw  = !(m >= S && m < S + ST);
                rwx  = !m_wr;
                if (m_n < T) begin
                    ado = m_addr; oe = 1'b0;
                end else if (m_wr) begin
                    ado = m_wdata; oe = 1'b0;
                end
            end
        end
        return {ready, bsy, rv, slot, crw, axd, rwx, ado, oe, m_rdata};
    endfunction

    // Monitor counters for the directed scenarios.
    int cnt_a_match, cnt_d_match, cnt_rwl, cnt_rsp, cnt_rwx0, cnt_oe_d, cnt_d, cnt_idle;
    logic [7:0] mon_addr, mon_wdata, mon_rsp_data;
    logic irq_chk = 1'b0;

    task automatic mon_clear(input logic [7:0] a, input logic [7:0] d);
        cnt_a_match = 0; cnt_d_match = 0; cnt_rwl = 0; cnt_rsp = 0;
        cnt_rwx0 = 0; cnt_oe_d = 0; cnt_d = 0; cnt_idle = 0;
        mon_addr = a; mon_wdata = d; mon_rsp_data = 8'h00;
    endtask

    // Compare process: every cycle the DUT outputs are set against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("bus_cycle",
                  {7'd0, cmd_ready, busy, rsp_valid, slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe_x, rsp_rdata},
                  {7'd0, model_vec()});
            if (irq_chk) check("irq_quiet", {31'd0, irq_pending}, 32'd0);
            if (rsp_valid) begin
                check("rsp_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("rsp_rdata_q", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
                mon_rsp_data = rsp_rdata;
            end
            if (!ax_d && !slot_x_int_x && ad_out == mon_addr) cnt_a_match++;
            if (ax_d && !slot_x_int_x && ad_out == mon_wdata) cnt_d_match++;
            if (ax_d && !slot_x_int_x) cnt_d++;
            if (ax_d && !slot_x_int_x && !ad_oe_x) cnt_oe_d++;
            if (!slot_x_int_x && !r_wx) cnt_rwx0++;
            if (!clk_rw) cnt_rwl++;
            if (rsp_valid) cnt_rsp++;
            if (!busy) cnt_idle++;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int t;
        t = 0;
        do begin step(); t++; end while (!(m_act && m_n == 0) && t < 60);
        check("accept_timeout", {31'd0, t < 60}, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_act && t < 100) begin step(); t++; end
        check("done_timeout", {31'd0, t < 100}, 32'd1);
    endtask

    task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mon_clear(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {7'd0, cmd_ready, busy, rsp_valid, slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe_x, rsp_rdata},
              {7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00});
        check("reset_irq", {31'd0, irq_pending}, 32'd0);
        rst = 1'b0;
        step(); step();

        // Write 0x12 / 0xA5
        mon_clear(8'h12, 8'hA5);
        do_cmd(1'b1, 8'h12, 8'hA5);
        check("wr_addr_cycles", cnt_a_match, 8);
        check("wr_data_cycles", cnt_d_match, 8);
        check("wr_strobe_low", cnt_rwl, 8);
        check("wr_rsp_pulses", cnt_rsp, 1);
        check("wr_rwx_low", cnt_rwx0, 16);
        check("wr_rdata_kept", {24'd0, rsp_rdata}, 32'h00);

        // Read 0x05, card returns 0x3C
        card_data = 8'h3C;
        mon_clear(8'h05, 8'hFF);
        do_cmd(1'b0, 8'h05, 8'h99);
        check("rd_addr_cycles", cnt_a_match, 8);
        check("rd_data_cycles", cnt_d, 8);
        check("rd_oe_in_data", cnt_oe_d, 0);
        check("rd_rwx_low", cnt_rwx0, 0);
        check("rd_rsp_pulses", cnt_rsp, 1);
        check("rd_rdata", {24'd0, mon_rsp_data}, 32'h3C);

        // Back-to-back with cmd_valid held high
        begin
            int t;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h77;
            wait_accept();
            mon_clear(8'h44, 8'hFF);
            cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'hFF; card_data = 8'h5A;
            wait_idle();
            t = 0;
            while (!m_act && t < 5) begin step(); t++; end
            check("b2b_second_accept", {31'd0, m_act}, 32'd1);
            check("b2b_idle_cycles", cnt_idle, 1);
            cmd_valid = 1'b0;
            wait_idle();
            step();
            check("b2b_second_addr", cnt_a_match, 8);
            check("b2b_second_rdata", {24'd0, mon_rsp_data}, 32'h5A);
        end

        // Reset during A_STROBE
        begin
            int t;
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h66;
            wait_accept();
            cmd_valid = 1'b0;
            t = 0;
            while (m_n != S && t < 20) begin step(); t++; end
            check("pre_reset_strobe", {31'd0, clk_rw}, 32'd0);
            #2 rst = 1'b1;
            #1;
            check("rst_clk_rw", {31'd0, clk_rw}, 32'd1);
            check("rst_slot", {31'd0, slot_x_int_x}, 32'd1);
            check("rst_oe", {31'd0, ad_oe_x}, 32'd1);
            mon_clear(8'h33, 8'h66);
            step();
            rst = 1'b0;
            check("rst_ready", {31'd0, cmd_ready}, 32'd1);
            repeat (20) step();
            check("rst_no_rsp", cnt_rsp, 0);
        end

`ifdef BKM_BUS_MASTER_IRQ_EN
        irq_x = 1'b0;
        step(); step();
        check("irq_not_yet", {31'd0, irq_pending}, 32'd0);
        step();
        check("irq_third_edge", {31'd0, irq_pending}, 32'd1);
        irq_clear = 1'b1;
        step(); step();
        check("irq_set_wins", {31'd0, irq_pending}, 32'd1);
        irq_clear = 1'b0;
        irq_x = 1'b1;
        step(); step();
        check("irq_still_set", {31'd0, irq_pending}, 32'd1);
        irq_clear = 1'b1;
        step();
        check("irq_cleared", {31'd0, irq_pending}, 32'd0);
        irq_clear = 1'b0;
`endif
        irq_chk = 1'b1;

        // Random traffic: command fields change every cycle, including while busy.
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) begin
                #($urandom_range(1, 3)) rst = 1'b1;
                step();
                rst = 1'b0;
            end
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
            card_data = 8'($urandom);
            junk      = 8'($urandom);
`ifdef BKM_BUS_MASTER_IRQ_EN
            irq_clear = 1'($urandom);
`else
            irq_x     = 1'($urandom);
            irq_clear = 1'($urandom);
`endif
            step();
        end
        cmd_valid = 1'b0;
        wait_idle();
        step();
        check("rsp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
